rr_req_gnt_arbiter: RTL and testbench

- N-channel round-robin request/grant arbiter with a built-in protocol monitor.
- Successor to the single request/grant pair check: arbitration is generalised to N_CH requesters, holds are bounded, and protocol and starvation violations are latched in sticky error flags rather than only asserted.
- Sits between shared-resource requesters and the resource; error flags feed the status/interrupt block.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 39 +++
 rtl/rr_req_gnt_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_req_gnt_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request/grant arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Channel index width, never less than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted req at index >= ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned IDW  = id_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [N_CH-1:0] win_oh,
  output logic [IDW-1:0]  win_id,
  output logic            any
);

  logic [N_CH-1:0] mask;
  logic [N_CH-1:0] masked;
  logic [N_CH-1:0] cand;

  // Requests at or above ptr win first; otherwise fall back to the lowest request.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    cand   = (|masked) ? masked : req;
    win_oh = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign win_id = IDW'(onehot_to_idx(16'(win_oh)));
  assign any    = |req;

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// N-channel round-robin arbiter with bounded hold and sticky drop/starvation monitors.
module rr_req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N_CH     = 4,
  parameter  int unsigned MAX_HOLD = 8,
  parameter  int unsigned MAX_WAIT = 32,
  localparam int unsigned IDW      = id_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  input  logic            err_clr,
  output logic [N_CH-1:0] err_drop,
  output logic [N_CH-1:0] err_starve,
  output logic            err_any
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d, id_d, next_ptr;
  logic [N_CH-1:0] gnt_d, req_q;
  logic [HW-1:0]   hold_q, hold_d;
  logic [WW-1:0]   wait_q [N_CH];
  logic [WW-1:0]   wait_d [N_CH];
  logic [N_CH-1:0] drop_set, starve_set, drop_d, starve_d;
  logic [N_CH-1:0] pick_oh;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic            owner_req, release_c;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .win_oh (pick_oh),
    .win_id (pick_id),
    .any    (pick_any)
  );

  assign next_ptr  = (pick_id == IDW'(N_CH - 1)) ? '0 : pick_id + IDW'(1);
  assign owner_req = |(req & gnt);
  // A forced release re-enters the owner into the pick; ptr = owner+1 puts it last.
  assign release_c = !owner_req || (hold_q == HW'(MAX_HOLD));

  // Next-state and grant decode.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          id_d    = pick_id;
          hold_d  = HW'(1);
          ptr_d   = next_ptr;
        end
      end
      GRANT: begin
        if (release_c) begin
          if (pick_any) begin
            gnt_d  = pick_oh;
            id_d   = pick_id;
            hold_d = HW'(1);
            ptr_d  = next_ptr;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-channel wait counters and sticky flag set/clear; set wins over clear.
  always_comb begin
    wait_d     = wait_q;
    drop_set   = '0;
    starve_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_set[i] = req_q[i] & ~req[i] & ~gnt[i];
      if (req[i] && !gnt[i]) begin
        if (wait_q[i] != WW'(MAX_WAIT)) wait_d[i] = wait_q[i] + WW'(1);
        starve_set[i] = (wait_d[i] == WW'(MAX_WAIT));
      end else begin
        wait_d[i] = '0;
      end
    end
    drop_d   = (err_drop & ~{N_CH{err_clr}}) | drop_set;
    starve_d = (err_starve & ~{N_CH{err_clr}}) | starve_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      req_q      <= '0;
      err_drop   <= '0;
      err_starve <= '0;
      err_any    <= 1'b0;
      for (int i = 0; i < N_CH; i++) wait_q[i] <= '0;
    end else begin
      gnt        <= gnt_d;
      gnt_valid  <= |gnt_d;
      gnt_id     <= id_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      req_q      <= req;
      err_drop   <= drop_d;
      err_starve <= starve_d;
      err_any    <= |(drop_d | starve_d);
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed bench for rr_req_gnt_arbiter: rotation, forced release, drop/starve flags, async reset.
module tb_rr_req_gnt_arbiter;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic [3:0] req, gnt, err_drop, err_starve;
  logic [1:0] gnt_id;
  logic       gnt_valid, err_any;
  logic [3:0] req_w, gnt_w, err_drop_w, err_starve_w;
  logic [1:0] gnt_id_w;
  logic       gnt_valid_w, err_any_w;

  int checks = 0;
  int errors = 0;

  rr_req_gnt_arbiter #(.N_CH(4), .MAX_HOLD(8), .MAX_WAIT(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .err_clr    (err_clr),
    .err_drop   (err_drop),
    .err_starve (err_starve),
    .err_any    (err_any)
  );

  rr_req_gnt_arbiter #(.N_CH(4), .MAX_HOLD(8), .MAX_WAIT(4)) u_dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_w),
    .gnt        (gnt_w),
    .gnt_valid  (gnt_valid_w),
    .gnt_id     (gnt_id_w),
    .err_clr    (err_clr),
    .err_drop   (err_drop_w),
    .err_starve (err_starve_w),
    .err_any    (err_any_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    req     = '0;
    req_w   = '0;
    err_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_gnt: gnt=%b valid=%b id=%0d, want 0000/0/0", gnt, gnt_valid, gnt_id);
    end
    checks++;
    if (err_drop !== 4'b0 || err_starve !== 4'b0 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: drop=%b starve=%b any=%b, want 0", err_drop, err_starve, err_any);
    end
  endtask

  task automatic test_single();
    apply_reset();
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL idle_gnt: gnt=%b, want 0000", gnt);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt=%b id=%0d valid=%b, want 0001/0/1", gnt, gnt_id, gnt_valid);
    end
    tick();
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL single_release: gnt=%b valid=%b id=%0d, want 0000/0/0", gnt, gnt_valid, gnt_id);
    end
    checks++;
    if (err_any !== 1'b0) begin
      errors++;
      $display("FAIL single_err_any: err_any=%b, want 0", err_any);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    int bad = 0;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_gnt = 4'(1 << ((k / 8) % 4));
      exp_id  = 2'((k / 8) % 4);
      checks++;
      if (gnt !== exp_gnt || gnt_id !== exp_id || gnt_valid !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL rotate k=%0d: gnt=%b id=%0d valid=%b, want %b/%0d/1",
                   k, gnt, gnt_id, gnt_valid, exp_gnt, exp_id);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || err_drop !== 4'b1110) begin
      errors++;
      $display("FAIL rotate_stop: gnt=%b drop=%b, want 0000/1110", gnt, err_drop);
    end
  endtask

  task automatic test_hold_self();
    logic [3:0] exp_gnt;
    apply_reset();
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_gnt = (k >= 16) ? 4'b1000 : 4'b0100;
      checks++;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL hold_self k=%0d: gnt=%b, want %b", k, gnt, exp_gnt);
      end
      if (k == 10) req = 4'b1100;
    end
  endtask

  task automatic test_drop();
    apply_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    tick();
    tick();
    req = 4'b0001;
    tick();
    checks++;
    if (err_drop !== 4'b0010 || err_any !== 1'b1) begin
      errors++;
      $display("FAIL drop_set: drop=%b any=%b, want 0010/1", err_drop, err_any);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_drop !== 4'b0000 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL drop_clr: drop=%b any=%b, want 0000/0", err_drop, err_any);
    end
    req = 4'b0011;
    tick();
    req     = 4'b0001;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_drop !== 4'b0010 || err_any !== 1'b1) begin
      errors++;
      $display("FAIL drop_set_wins: drop=%b any=%b, want 0010/1", err_drop, err_any);
    end
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL drop_owner: gnt=%b, want 0001", gnt);
    end
  endtask

  task automatic test_starve();
    apply_reset();
    req_w = 4'b1001;
    tick();
    tick();
    tick();
    checks++;
    if (err_starve_w !== 4'b0000) begin
      errors++;
      $display("FAIL starve_early: starve=%b, want 0000", err_starve_w);
    end
    tick();
    checks++;
    if (err_starve_w !== 4'b1000 || err_any_w !== 1'b1) begin
      errors++;
      $display("FAIL starve_set: starve=%b any=%b, want 1000/1", err_starve_w, err_any_w);
    end
    checks++;
    if (gnt_w !== 4'b0001 || err_drop_w !== 4'b0000) begin
      errors++;
      $display("FAIL starve_ch0: gnt=%b drop=%b, want 0001/0000", gnt_w, err_drop_w);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    tick();
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || err_drop !== 4'b0010) begin
      errors++;
      $display("FAIL pre_reset: gnt=%b drop=%b, want 0001/0010", gnt, err_drop);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 ||
        err_drop !== 4'b0000 || err_any !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b valid=%b id=%0d drop=%b any=%b, want all 0",
               gnt, gnt_valid, gnt_id, err_drop, err_any);
    end
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
    req   = 4'b1000;
    tick();
    checks++;
    if (gnt_id !== 2'd3 || gnt !== 4'b1000 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: gnt=%b id=%0d valid=%b, want 1000/3/1", gnt, gnt_id, gnt_valid);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    req_w   = '0;
    err_clr = 1'b0;
    test_reset();
    test_single();
    test_rotate();
    test_hold_self();
    test_drop();
    test_starve();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
